// File: rtl/instr_aligner.sv
// Fetch realigner: word reads in, one RVC parcel or (possibly straddling) 32-bit instruction out.
// Output is combinational from the 3-halfword buffer; out_ready_i low stalls fetch once 2+ halfwords are held.
module instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_compressed_o,
  output logic [31:0] out_pc_o
);

  // Slot i lives in hbuf[16*i +: 16]; slot 0 is the oldest halfword, at hpc.
  logic [47:0] hbuf_q, hbuf_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [31:0] hpc_q, hpc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        skip_lo_q, skip_lo_d;

  logic [15:0] slot0;
  logic        slot0_rvc, rvc_rdy, full_rdy;
  logic        req_fire, rsp_fire, rsp_keep, accept;
  logic [1:0]  shamt, cnt_s, nin;
  logic [47:0] buf_s;
  logic [15:0] first_half;

  assign slot0     = hbuf_q[15:0];
  assign slot0_rvc = (slot0[1:0] != 2'b11);
  assign rvc_rdy   = (hcnt_q != 2'd0) && slot0_rvc;
  assign full_rdy  = (hcnt_q >= 2'd2) && !slot0_rvc;

  assign out_valid_o      = (rvc_rdy || full_rdy) && !redirect_i;
  assign out_compressed_o = rvc_rdy;
  assign out_instr_o      = rvc_rdy  ? {16'h0000, slot0} :
                            full_rdy ? hbuf_q[31:0] : 32'h0000_0000;
  assign out_pc_o         = hpc_q;

  // rst_n gating keeps the request quiet while the block is held in reset.
  assign mem_req_valid_o = rst_n && !outstanding_q && (hcnt_q <= 2'd1) && !redirect_i;
  assign mem_addr_o      = fetch_pc_q;

  assign req_fire = mem_req_valid_o && mem_req_ready_i;
  assign rsp_fire = mem_rsp_valid_i && outstanding_q;
  assign rsp_keep = rsp_fire && !discard_q;
  assign accept   = out_valid_o && out_ready_i;

  assign shamt      = accept ? (rvc_rdy ? 2'd1 : 2'd2) : 2'd0;
  assign cnt_s      = hcnt_q - shamt;
  assign buf_s      = hbuf_q >> {shamt, 4'b0000};
  assign first_half = skip_lo_q ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0];
  assign nin        = skip_lo_q ? 2'd1 : 2'd2;

  always_comb begin
    hbuf_d        = buf_s;
    hcnt_d        = cnt_s;
    hpc_d         = hpc_q + {29'b0, shamt, 1'b0};
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    skip_lo_d     = skip_lo_q;

    // Shift out the accepted instruction first, then append new halfwords behind what remains.
    if (rsp_keep) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) == cnt_s) begin
          hbuf_d[16*i +: 16] = first_half;
        end else if ((2'(i) == cnt_s + 2'd1) && !skip_lo_q) begin
          hbuf_d[16*i +: 16] = mem_rsp_data_i[31:16];
        end
      end
      hcnt_d    = cnt_s + nin;
      skip_lo_d = 1'b0;
    end

    if (req_fire) begin
      outstanding_d = 1'b1;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
    if (rsp_fire) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end

    // A response landing in the redirect cycle is the stale one; otherwise arm the discard.
    if (redirect_i) begin
      hcnt_d        = 2'd0;
      hpc_d         = {redirect_pc_i[31:1], 1'b0};
      fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
      skip_lo_d     = redirect_pc_i[1];
      discard_d     = outstanding_q && !mem_rsp_valid_i;
      outstanding_d = outstanding_q && !mem_rsp_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hbuf_q        <= '0;
      hcnt_q        <= 2'd0;
      hpc_q         <= {RESET_PC[31:1], 1'b0};
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      skip_lo_q     <= RESET_PC[1];
    end else begin
      hbuf_q        <= hbuf_d;
      hcnt_q        <= hcnt_d;
      hpc_q         <= hpc_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      skip_lo_q     <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner with a small in-order memory responder of configurable latency.
module tb_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_compressed_o;
  logic [31:0] out_pc_o;

  instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_compressed_o (out_compressed_o),
    .out_pc_o         (out_pc_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        cmp;
  } obs_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  obs_t        obs_q [$];
  logic [31:0] req_q [$];
  logic        pend_vld;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat;
  logic        last_rsp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // One clock: drive the response for this cycle, record handshakes, then advance to the next negedge.
  task automatic tick();
    logic        fired;
    logic [31:0] faddr;
    if (pend_vld && pend_wait == 0) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = rd(pend_addr);
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = 32'h0;
    end
    #1;
    last_rsp = mem_rsp_valid_i;
    fired    = mem_req_valid_o && mem_req_ready_i;
    faddr    = mem_addr_o;
    if (out_valid_o && out_ready_i)
      obs_q.push_back('{instr: out_instr_o, pc: out_pc_o, cmp: out_compressed_o});
    @(posedge clk);
    if (mem_rsp_valid_i) pend_vld = 1'b0;
    else if (pend_vld && pend_wait > 0) pend_wait--;
    if (fired) begin
      pend_vld  = 1'b1;
      pend_addr = faddr;
      pend_wait = lat - 1;
      req_q.push_back(faddr);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'h0;
    out_ready_i     = 1'b0;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = 32'h0;
    pend_vld        = 1'b0;
    pend_wait       = 0;
    lat             = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    req_q.delete();
    mem.delete();
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'h0;
    out_ready_i     = 1'b1;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = 32'h0;
    @(negedge clk);
    total++;
    if (out_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || out_compressed_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: out_valid=%b req_valid=%b compressed=%b want 0 0 0",
               out_valid_o, mem_req_valid_o, out_compressed_o);
    end
    total++;
    if (mem_addr_o !== 32'h0 || out_pc_o !== 32'h0 || out_instr_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h pc=%h instr=%h want 0 0 0", mem_addr_o, out_pc_o, out_instr_o);
    end
  endtask

  task automatic test_basic();
    obs_t e [3];
    e[0] = '{instr: 32'h0000_4501, pc: 32'h0, cmp: 1'b1};
    e[1] = '{instr: 32'h0000_0001, pc: 32'h2, cmp: 1'b1};
    e[2] = '{instr: 32'h0000_0013, pc: 32'h4, cmp: 1'b0};
    apply_reset();
    mem[32'h0] = 32'h0001_4501;
    mem[32'h4] = 32'h0000_0013;
    out_ready_i = 1'b1;
    tick();
    tick();
    total++;
    if (obs_q.size() !== 0) begin
      bad++;
      $display("FAIL basic_early: outputs=%0d before response settled, want 0", obs_q.size());
    end
    tick();
    total++;
    if (obs_q.size() !== 1) begin
      bad++;
      $display("FAIL basic_latency: outputs=%0d one cycle after response, want 1", obs_q.size());
    end
    for (int n = 0; n < 40 && obs_q.size() < 3; n++) tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_q.size() <= i || obs_q[i] !== e[i]) begin
        bad++;
        $display("FAIL basic_out%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : '0, e[i]);
      end
    end
  endtask

  task automatic test_straddle();
    obs_t e [2];
    e[0] = '{instr: 32'h0000_4505, pc: 32'h0, cmp: 1'b1};
    e[1] = '{instr: 32'h0010_0093, pc: 32'h2, cmp: 1'b0};
    apply_reset();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h0000_0010;
    out_ready_i = 1'b1;
    for (int n = 0; n < 40 && obs_q.size() < 2; n++) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs_q.size() <= i || obs_q[i] !== e[i]) begin
        bad++;
        $display("FAIL straddle_out%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : '0, e[i]);
      end
    end
  endtask

  task automatic test_redirect();
    obs_t e0;
    bit   found;
    e0 = '{instr: 32'h0000_4A85, pc: 32'h106, cmp: 1'b1};
    found = 0;
    apply_reset();
    mem[32'h10]  = 32'h1111_1111;
    mem[32'h104] = 32'h4A85_FFFF;
    lat = 3;
    out_ready_i = 1'b1;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (req_q.size() > 0 && req_q[$] == 32'h10) found = 1;
    end
    total++;
    if (!found || pend_vld !== 1'b1) begin
      bad++;
      $display("FAIL redir_setup: request to 0x10 outstanding=%b want 1", found && pend_vld);
    end
    obs_q.delete();
    req_q.delete();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0106;
    tick();
    redirect_i = 1'b0;
    total++;
    if (req_q.size() !== 0 || obs_q.size() !== 0) begin
      bad++;
      $display("FAIL redir_cycle: reqs=%0d outs=%0d in redirect cycle, want 0 0", req_q.size(), obs_q.size());
    end
    for (int n = 0; n < 60 && obs_q.size() < 1; n++) tick();
    total++;
    if (req_q.size() < 1 || req_q[0] !== 32'h104) begin
      bad++;
      $display("FAIL redir_addr: first request %h want 00000104", (req_q.size() > 0) ? req_q[0] : 32'hx);
    end
    total++;
    if (obs_q.size() < 1 || obs_q[0] !== e0) begin
      bad++;
      $display("FAIL redir_out: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : '0, e0);
    end
  endtask

  task automatic test_stall();
    obs_t e [5];
    bit   held_ok;
    int   nreq4;
    e[0] = '{instr: 32'h0000_0005, pc: 32'h2, cmp: 1'b1};
    e[1] = '{instr: 32'h0000_0009, pc: 32'h4, cmp: 1'b1};
    e[2] = '{instr: 32'h0000_000D, pc: 32'h6, cmp: 1'b1};
    e[3] = '{instr: 32'h0000_0011, pc: 32'h8, cmp: 1'b1};
    e[4] = '{instr: 32'h0000_0015, pc: 32'hA, cmp: 1'b1};
    held_ok = 1;
    nreq4   = 0;
    apply_reset();
    mem[32'h0] = 32'h0005_0001;
    mem[32'h4] = 32'h000D_0009;
    mem[32'h8] = 32'h0015_0011;
    mem[32'hC] = 32'h0019_001D;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0002;
    tick();
    redirect_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) nreq4 = req_q.size();
      if (k >= 4) begin
        #1;
        if (!(out_valid_o === 1'b1 && out_instr_o === 32'h5 && out_pc_o === 32'h2 && out_compressed_o === 1'b1))
          held_ok = 0;
      end
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL stall_hold: outputs changed while stalled (now instr=%h pc=%h) want 00000005 @ 00000002",
               out_instr_o, out_pc_o);
    end
    total++;
    if (req_q.size() !== 2 || nreq4 !== 2) begin
      bad++;
      $display("FAIL stall_reqs: requests=%0d (at fill %0d) want 2 2", req_q.size(), nreq4);
    end
    out_ready_i = 1'b1;
    for (int n = 0; n < 60 && obs_q.size() < 5; n++) tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs_q.size() <= i || obs_q[i] !== e[i]) begin
        bad++;
        $display("FAIL stall_drain%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : '0, e[i]);
      end
    end
  endtask

  task automatic test_accept_rsp();
    obs_t e [4];
    e[0] = '{instr: 32'h0000_0005, pc: 32'h2, cmp: 1'b1};
    e[1] = '{instr: 32'h0000_0009, pc: 32'h4, cmp: 1'b1};
    e[2] = '{instr: 32'h0000_000D, pc: 32'h6, cmp: 1'b1};
    e[3] = '{instr: 32'h0000_0011, pc: 32'h8, cmp: 1'b1};
    apply_reset();
    mem[32'h0] = 32'h0005_0001;
    mem[32'h4] = 32'h000D_0009;
    mem[32'h8] = 32'h0015_0011;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0002;
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    tick();
    out_ready_i = 1'b1;
    tick();
    total++;
    if (last_rsp !== 1'b1 || obs_q.size() !== 1) begin
      bad++;
      $display("FAIL accrsp_same_cycle: rsp=%b accepts=%0d want 1 1", last_rsp, obs_q.size());
    end
    for (int n = 0; n < 60 && obs_q.size() < 4; n++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_q.size() <= i || obs_q[i] !== e[i]) begin
        bad++;
        $display("FAIL accrsp_out%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : '0, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e0;
    e0 = '{instr: 32'h0000_4501, pc: 32'h0, cmp: 1'b1};
    apply_reset();
    mem[32'h0] = 32'h0001_4501;
    mem[32'h4] = 32'h0000_0013;
    out_ready_i = 1'b1;
    tick();
    tick();
    tick();
    #1;
    total++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h2) begin
      bad++;
      $display("FAIL rstmid_pre: valid=%b pc=%h want 1 00000002", out_valid_o, out_pc_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || out_compressed_o !== 1'b0 ||
        mem_addr_o !== 32'h0 || out_pc_o !== 32'h0 || out_instr_o !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_async: valid=%b req=%b cmp=%b addr=%h pc=%h instr=%h want all 0",
               out_valid_o, mem_req_valid_o, out_compressed_o, mem_addr_o, out_pc_o, out_instr_o);
    end
    pend_vld = 1'b0;
    obs_q.delete();
    req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (req_q.size() !== 1 || req_q[0] !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_req: reqs=%0d first=%h want 1 00000000", req_q.size(),
               (req_q.size() > 0) ? req_q[0] : 32'hx);
    end
    for (int n = 0; n < 20 && obs_q.size() < 1; n++) tick();
    total++;
    if (obs_q.size() < 1 || obs_q[0] !== e0) begin
      bad++;
      $display("FAIL rstmid_out: got %h want %h", (obs_q.size() > 0) ? obs_q[0] : '0, e0);
    end
  endtask

  initial begin
    pend_vld  = 1'b0;
    pend_addr = 32'h0;
    pend_wait = 0;
    lat       = 1;
    last_rsp  = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_redirect();
    test_stall();
    test_accept_rsp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
